// File: rtl/pma_pkg.sv
// pma_pkg: shared types and constants for the 100BASE-X PMA stage.
//   link_state_e       - link monitor states
//   LINK_TIMER_DEFAULT - default link hysteresis length (330 us at 125 MHz)
//   rx_beat_t          - one cycle of receive data toward the PCS
package pma_pkg;

  localparam int unsigned LINK_TIMER_DEFAULT = 41250;

  typedef enum logic [1:0] {
    LINK_DOWN  = 2'd0,
    HYSTERESIS = 2'd1,
    LINK_UP    = 2'd2
  } link_state_e;

  // Bit [1] of bits is the oldest, matching the PMD ordering.
  typedef struct packed {
    logic [1:0] bits;
    logic [1:0] valid;
  } rx_beat_t;

endpackage : pma_pkg

// File: rtl/pma_link_monitor.sv
// pma_link_monitor: synchronizes the PMD signal detect and qualifies it with
// a hysteresis timer before declaring the link up.
//   clk, rst      - bit clock, async active-high reset
//   signal_status - PMD signal detect, asynchronous to clk
//   link_status   - registered link-up indication
module pma_link_monitor
  import pma_pkg::*;
#(
  parameter int unsigned LINK_TIMER = LINK_TIMER_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_status,
  output logic link_status
);

  localparam int unsigned CNT_W = $clog2(LINK_TIMER + 1);

  logic             sync1_q;
  logic             sync2_q;
  link_state_e      state_q;
  link_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             link_q;
  logic             link_d;

  // Two-flop synchronizer for the asynchronous signal detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= signal_status;
      sync2_q <= sync1_q;
    end
  end

  // State, counter and link output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LINK_DOWN;
      cnt_q   <= '0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      link_q  <= link_d;
    end
  end

  // Next state; link output follows the next state so it is high exactly
  // while the registered state is LINK_UP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LINK_DOWN: begin
        if (sync2_q) begin
          state_d = HYSTERESIS;
          cnt_d   = CNT_W'(LINK_TIMER - 1);
        end
      end
      HYSTERESIS: begin
        if (!sync2_q) begin
          state_d = LINK_DOWN;
        end else if (cnt_q == '0) begin
          state_d = LINK_UP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LINK_UP: begin
        if (!sync2_q) begin
          state_d = LINK_DOWN;
        end
      end
      default: state_d = LINK_DOWN;
    endcase
    link_d = (state_d == LINK_UP);
  end

  assign link_status = link_q;

endmodule : pma_link_monitor

// File: rtl/pma.sv
// pma: 100BASE-X PMA stage between the PCS and the PMD.
//   clk, rst          - 125 MHz bit clock, async active-high reset
//   pma_data_tx       - PCS code bit, one per cycle
//   pmd_data_tx       - NRZI line bit toward the PMD (1 cycle latency)
//   pmd_data_rx       - recovered NRZI bits, [1] oldest
//   pmd_data_rx_valid - number of valid recovered bits (0..2, 3 treated as 2)
//   signal_status     - PMD signal detect, asynchronous
//   pma_data_rx       - NRZI-decoded bits toward the PCS (1 cycle latency)
//   pma_data_rx_valid - registered valid count
//   link_status       - link up
module pma
  import pma_pkg::*;
#(
  parameter int unsigned LINK_TIMER = LINK_TIMER_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pma_data_tx,
  output logic       pmd_data_tx,
  input  logic [1:0] pmd_data_rx,
  input  logic [1:0] pmd_data_rx_valid,
  input  logic       signal_status,
  output logic [1:0] pma_data_rx,
  output logic [1:0] pma_data_rx_valid,
  output logic       link_status
);

  logic     tx_q;
  logic     tx_d;
  rx_beat_t rx_q;
  rx_beat_t rx_d;
  logic     last_q;
  logic     last_d;

  // TX NRZI: a code bit of 1 toggles the line level.
  assign tx_d = tx_q ^ pma_data_tx;

  // RX NRZI: a decoded 1 is a change of line level; last holds the most
  // recent valid level so decoding continues across idle cycles.
  always_comb begin
    rx_d   = '0;
    last_d = last_q;
    unique case (pmd_data_rx_valid)
      2'd0: ;
      2'd1: begin
        rx_d.bits  = {pmd_data_rx[1] ^ last_q, 1'b0};
        rx_d.valid = 2'd1;
        last_d     = pmd_data_rx[1];
      end
      default: begin
        rx_d.bits  = {pmd_data_rx[1] ^ last_q, pmd_data_rx[0] ^ pmd_data_rx[1]};
        rx_d.valid = 2'd2;
        last_d     = pmd_data_rx[0];
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= 1'b0;
      rx_q   <= '0;
      last_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      last_q <= last_d;
    end
  end

  assign pmd_data_tx       = tx_q;
  assign pma_data_rx       = rx_q.bits;
  assign pma_data_rx_valid = rx_q.valid;

  pma_link_monitor #(
    .LINK_TIMER(LINK_TIMER)
  ) u_link_monitor (
    .clk          (clk),
    .rst          (rst),
    .signal_status(signal_status),
    .link_status  (link_status)
  );

endmodule : pma

// File: tb/tb_pma.sv
// tb_pma: self-checking bench for pma. Expected values are queued when
// stimulus is driven and compared one edge later when the DUT responds.
module tb_pma;

  localparam int unsigned LT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pma_data_tx = 1'b0;
  logic       pmd_data_tx;
  logic [1:0] pmd_data_rx = 2'b00;
  logic [1:0] pmd_data_rx_valid = 2'b00;
  logic       signal_status = 1'b0;
  logic [1:0] pma_data_rx;
  logic [1:0] pma_data_rx_valid;
  logic       link_status;

  int n_checks = 0;
  int n_fail   = 0;

  logic       tx_exp_q[$];
  logic [3:0] rx_exp_q[$];
  logic       link_exp_q[$];

  logic m_line = 1'b0;
  logic m_last = 1'b0;

  pma #(.LINK_TIMER(LT)) dut (
    .clk              (clk),
    .rst              (rst),
    .pma_data_tx      (pma_data_tx),
    .pmd_data_tx      (pmd_data_tx),
    .pmd_data_rx      (pmd_data_rx),
    .pmd_data_rx_valid(pmd_data_rx_valid),
    .signal_status    (signal_status),
    .pma_data_rx      (pma_data_rx),
    .pma_data_rx_valid(pma_data_rx_valid),
    .link_status      (link_status)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a TX bit and queue the expected line level.
  task automatic drive_tx(input logic b);
    pma_data_tx = b;
    m_line      = m_line ^ b;
    tx_exp_q.push_back(m_line);
  endtask

  // Drive an RX beat and queue the decoded result from the NRZI rules.
  task automatic drive_rx(input logic [1:0] b, input logic [1:0] v);
    logic [1:0] eb;
    logic [1:0] ev;
    pmd_data_rx       = b;
    pmd_data_rx_valid = v;
    if (v == 2'd0) begin
      eb = 2'b00; ev = 2'd0;
    end else if (v == 2'd1) begin
      eb = {b[1] ^ m_last, 1'b0}; ev = 2'd1; m_last = b[1];
    end else begin
      eb = {b[1] ^ m_last, b[0] ^ b[1]}; ev = 2'd2; m_last = b[0];
    end
    rx_exp_q.push_back({eb, ev});
  endtask

  task automatic check_tx(input string name);
    logic e;
    e = tx_exp_q.pop_front();
    n_checks++;
    if (pmd_data_tx !== e) begin
      n_fail++;
      $display("FAIL %s: pmd_data_tx got %b expected %b", name, pmd_data_tx, e);
    end
  endtask

  task automatic check_rx(input string name);
    logic [3:0] e;
    e = rx_exp_q.pop_front();
    n_checks++;
    if ({pma_data_rx, pma_data_rx_valid} !== e) begin
      n_fail++;
      $display("FAIL %s: rx/valid got %b/%0d expected %b/%0d", name,
               pma_data_rx, pma_data_rx_valid, e[3:2], e[1:0]);
    end
  endtask

  task automatic check_link(input string name, input int edge_n);
    logic e;
    e = link_exp_q.pop_front();
    n_checks++;
    if (link_status !== e) begin
      n_fail++;
      $display("FAIL %s: link_status at edge %0d got %b expected %b", name, edge_n, link_status, e);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({pmd_data_tx, pma_data_rx, pma_data_rx_valid, link_status} !== 6'b0) begin
      n_fail++;
      $display("FAIL %s: tx=%b rx=%b valid=%0d link=%b expected all 0", name,
               pmd_data_tx, pma_data_rx, pma_data_rx_valid, link_status);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1 check_all_zero("reset_async");
    tick();
    tick();
    check_all_zero("reset_held");
    rst    = 1'b0;
    m_line = 1'b0;
    m_last = 1'b0;
  endtask

  task automatic test_tx_encode();
    logic stim[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic want[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic got;
    for (int i = 0; i < 5; i++) begin
      drive_tx(stim[i]);
      drive_rx(2'b00, 2'd0);
      tick();
      got = pmd_data_tx;
      check_tx("tx_encode");
      check_rx("rx_idle");
      n_checks++;
      if (got !== want[i]) begin
        n_fail++;
        $display("FAIL tx_table[%0d]: got %b expected %b", i, got, want[i]);
      end
    end
    drive_tx(1'b0);
    tx_exp_q.delete();
  endtask

  task automatic test_rx_two_bit();
    logic [1:0] in_b[3] = '{2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      drive_rx(in_b[i], 2'd2);
      tick();
      check_rx("rx_two_bit");
    end
  endtask

  // Alternating line levels: every valid decoded bit must be 1.
  task automatic test_rx_mixed();
    logic       lvl;
    logic [1:0] v;
    logic [1:0] b;
    logic [1:0] junk;
    logic [3:0] e;
    lvl = m_last;
    for (int i = 0; i < 30; i++) begin
      v    = (i == 10) ? 2'd3 : 2'($urandom_range(0, 2));
      junk = 2'($urandom_range(0, 3));
      if (v == 2'd0) begin
        b = junk; e = 4'b00_00;
      end else if (v == 2'd1) begin
        b = {~lvl, junk[0]}; lvl = ~lvl; e = 4'b10_01;
      end else begin
        b = {~lvl, lvl}; e = 4'b11_10;
      end
      drive_rx(b, v);
      void'(rx_exp_q.pop_back());
      rx_exp_q.push_back(e);
      tick();
      check_rx("rx_mixed");
    end
    drive_rx(2'b00, 2'd0);
    tick();
    check_rx("rx_mixed_idle");
  endtask

  task automatic test_link_up();
    signal_status = 1'b1;
    for (int n = 1; n <= LT + 5; n++) begin
      link_exp_q.push_back(n >= LT + 3);
      tick();
      check_link("link_up", n);
    end
    signal_status = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      link_exp_q.push_back(n < 3);
      tick();
      check_link("link_down", n);
    end
  endtask

  task automatic test_hysteresis_abort();
    signal_status = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      if (n == 7) signal_status = 1'b0;
      link_exp_q.push_back(1'b0);
      tick();
      check_link("abort_pre", n);
    end
    signal_status = 1'b1;
    for (int n = 1; n <= LT + 3; n++) begin
      link_exp_q.push_back(n == LT + 3);
      tick();
      check_link("abort_rerise", n);
    end
    signal_status = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      link_exp_q.push_back(n < 3);
      tick();
      check_link("abort_down", n);
    end
  endtask

  task automatic test_reset_mid();
    signal_status = 1'b1;
    for (int n = 1; n <= LT + 3; n++) begin
      drive_tx(1'($urandom_range(0, 1)));
      drive_rx(2'($urandom_range(0, 3)), 2'd2);
      link_exp_q.push_back(n == LT + 3);
      tick();
      check_tx("mid_tx");
      check_rx("mid_rx");
      check_link("mid_link_up", n);
    end
    drive_tx(1'b1);
    drive_rx(2'b01, 2'd2);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset_async");
    tick();
    check_all_zero("mid_reset_held");
    tx_exp_q.delete();
    rx_exp_q.delete();
    rst    = 1'b0;
    m_line = 1'b0;
    m_last = 1'b0;
    for (int n = 1; n <= LT + 3; n++) begin
      drive_tx(1'b1);
      drive_rx({n[0], 1'b0}, 2'd1);
      link_exp_q.push_back(n == LT + 3);
      tick();
      check_tx("post_reset_tx");
      check_rx("post_reset_rx");
      check_link("post_reset_link", n);
    end
  endtask

  initial begin
    test_reset();
    test_tx_encode();
    test_rx_two_bit();
    test_rx_mixed();
    test_link_up();
    test_hysteresis_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pma
